// File: rtl/adc_pkt_pkg.sv
// Shared types, widths and helpers for the ADC trigger packetizer.
// Sum-width sizing keeps at least one guard bit even for a single channel.
package adc_pkt_pkg;

    localparam int unsigned LANE_W = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDrain   = 2'd3
    } pkt_state_e;

    function automatic int unsigned clog2_min1(int unsigned n);
        int unsigned lg;
        lg = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << lg) < n) lg++;
        end
        return (lg < 1) ? 1 : lg;
    endfunction

    function automatic int unsigned sum_width(int unsigned data_w, int unsigned num_ch);
        return data_w + clog2_min1(num_ch);
    endfunction

    // Bit pattern of the most-negative value of a w-bit signed number.
    function automatic logic [63:0] most_neg(int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/adc_trig_packetizer_if.sv
// AXI-Stream output bundle of the packetizer.
interface adc_trig_packetizer_if
    import adc_pkt_pkg::*;
#(
    parameter int unsigned NUM_CH = 2
);
    logic [NUM_CH*LANE_W-1:0] tdata;
    logic                     tvalid;
    logic                     tready;
    logic                     tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_decimator.sv
// Single-channel averaging decimator: sums 2^d samples and emits the arithmetic mean.
// The exponent is captured at the start of each frame so mid-frame changes wait a frame.
module adc_decimator
    import adc_pkt_pkg::*;
#(
    parameter int unsigned ADC_DATA_WIDTH = 14,
    parameter int unsigned MAX_DEC_LOG2   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic signed [ADC_DATA_WIDTH-1:0] sample,
    input  logic                             valid,
    input  logic [3:0]                       dec_log2,
    output logic signed [ADC_DATA_WIDTH-1:0] dec,
    output logic                             dec_valid
);
    localparam int unsigned AccW = ADC_DATA_WIDTH + MAX_DEC_LOG2;
    localparam int unsigned CntW = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;

    logic signed [AccW-1:0]           acc_q, acc_d, acc_sum;
    logic [CntW-1:0]                  cnt_q, cnt_d, last_cnt;
    logic [3:0]                       d_q, d_d, d_eff;
    logic signed [ADC_DATA_WIDTH-1:0] out_q, out_d;
    logic                             vld_q, vld_d;

    always_comb begin
        d_eff    = (cnt_q == '0) ? dec_log2 : d_q;
        last_cnt = ~({CntW{1'b1}} << d_eff);
        acc_sum  = acc_q + AccW'(sample);
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        out_d    = out_q;
        vld_d    = 1'b0;
        if (valid) begin
            if (cnt_q == '0) d_d = dec_log2;
            if (cnt_q == last_cnt) begin
                cnt_d = '0;
                acc_d = '0;
                out_d = ADC_DATA_WIDTH'(acc_sum >>> d_eff);
                vld_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            d_q   <= '0;
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            d_q   <= d_d;
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign dec       = out_q;
    assign dec_valid = vld_q;

endmodule

// File: rtl/adc_trig_packetizer.sv
// ADC capture front end: per-channel decimation, hysteretic level trigger on the channel
// sum, and fixed-length AXI-Stream packets through a single-entry output register.
module adc_trig_packetizer
    import adc_pkt_pkg::*;
#(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned ADC_DATA_WIDTH = 14,
    parameter int unsigned PKT_LEN        = 256,
    parameter int unsigned MAX_DEC_LOG2   = 8,
    localparam int unsigned SUM_W         = sum_width(ADC_DATA_WIDTH, NUM_CH)
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [NUM_CH*LANE_W-1:0]   adc_dat,
    input  logic                       adc_valid,
    input  logic [3:0]                 dec_log2,
    input  logic signed [SUM_W-1:0]    trig_level,
    input  logic [SUM_W-1:0]           trig_hyst,
    input  logic                       arm,
    input  logic                       abort,
    input  logic                       clear_stats,
    adc_trig_packetizer_if.master      m_axis,
    output logic [1:0]                 state,
    output logic [63:0]                sample_ts,
    output logic [63:0]                trig_ts,
    output logic [15:0]                trig_count,
    output logic [15:0]                overrun_count,
    output logic signed [SUM_W-1:0]    max_sum
);
    localparam int unsigned BeatW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(PKT_LEN - 1);
    localparam logic signed [SUM_W-1:0] SumMin = SUM_W'(most_neg(SUM_W));

    logic [3:0]                       dec_eff;
    logic signed [ADC_DATA_WIDTH-1:0] lane_in  [NUM_CH];
    logic signed [ADC_DATA_WIDTH-1:0] dec_lane [NUM_CH];
    logic [NUM_CH-1:0]                lane_dv;
    logic                             dec_valid;
    logic                             unused_adc_hi;

    assign dec_eff = (dec_log2 > 4'(MAX_DEC_LOG2)) ? 4'(MAX_DEC_LOG2) : dec_log2;
    // Only the low ADC_DATA_WIDTH bits of each lane carry data.
    assign unused_adc_hi = ^adc_dat;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign lane_in[k] = adc_dat[k*LANE_W +: ADC_DATA_WIDTH];
        adc_decimator #(
            .ADC_DATA_WIDTH (ADC_DATA_WIDTH),
            .MAX_DEC_LOG2   (MAX_DEC_LOG2)
        ) u_dec (
            .clk       (aclk),
            .rst       (areset),
            .sample    (lane_in[k]),
            .valid     (adc_valid),
            .dec_log2  (dec_eff),
            .dec       (dec_lane[k]),
            .dec_valid (lane_dv[k])
        );
    end

    assign dec_valid = &lane_dv;

    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W:0]    thr;
    logic                     below_hit;
    logic [NUM_CH*LANE_W-1:0] beat_data;

    always_comb begin
        sum       = '0;
        beat_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = sum + SUM_W'(dec_lane[k]);
            beat_data[k*LANE_W +: LANE_W] = LANE_W'(dec_lane[k]);
        end
        thr       = (SUM_W+1)'(trig_level) - $signed({1'b0, trig_hyst});
        below_hit = (SUM_W+1)'(sum) < thr;
    end

    pkt_state_e               state_q, state_d;
    logic                     below_q, below_d;
    logic [BeatW-1:0]         beat_q, beat_d;
    logic [63:0]              ts_q, ts_d, trig_ts_q, trig_ts_d;
    logic [15:0]              trig_cnt_q, trig_cnt_d, ovr_q, ovr_d;
    logic signed [SUM_W-1:0]  max_q, max_d;
    logic [NUM_CH*LANE_W-1:0] tdata_q, tdata_d;
    logic                     tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic                     trig_hit, emit, emit_last;

    always_comb begin
        state_d    = state_q;
        below_d    = below_q;
        beat_d     = beat_q;
        ts_d       = ts_q;
        trig_ts_d  = trig_ts_q;
        trig_cnt_d = trig_cnt_q;
        ovr_d      = ovr_q;
        max_d      = max_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        emit       = 1'b0;
        emit_last  = 1'b0;
        trig_hit   = (state_q == StArmed) && dec_valid && below_q && (sum >= trig_level) &&
                     !abort;

        if (tvalid_q && m_axis.tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        if (dec_valid) begin
            ts_d = ts_q + 64'd1;
            if (below_hit) below_d = 1'b1;
            if (sum > max_q) max_d = sum;
        end

        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d = StArmed;
                    below_d = 1'b0;
                end
            end
            StArmed: begin
                if (trig_hit) begin
                    state_d   = StCapture;
                    trig_ts_d = ts_q;
                    below_d   = 1'b0;
                    emit      = 1'b1;
                    beat_d    = BeatW'(1);
                    if (trig_cnt_q != 16'hFFFF) trig_cnt_d = trig_cnt_q + 16'd1;
                end
            end
            StCapture: begin
                if (dec_valid && !abort) begin
                    emit      = 1'b1;
                    emit_last = (beat_q == LastBeat);
                    beat_d    = beat_q + BeatW'(1);
                    if (emit_last) begin
                        state_d = StDrain;
                        beat_d  = '0;
                    end
                end
            end
            StDrain: begin
                if (!tvalid_q) begin
                    state_d = StArmed;
                    below_d = 1'b0;
                end
            end
        endcase

        if (emit) begin
            if (!tvalid_q || m_axis.tready) begin
                tdata_d  = beat_data;
                tvalid_d = 1'b1;
                tlast_d  = emit_last;
            end else begin
                if (ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;
                // A dropped final beat must still close the packet via the held beat.
                if (emit_last) tlast_d = 1'b1;
            end
        end

        if (clear_stats) begin
            max_d      = SumMin;
            trig_cnt_d = '0;
            ovr_d      = '0;
        end

        if (abort) begin
            state_d  = StIdle;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            beat_d   = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= StIdle;
            below_q    <= 1'b0;
            beat_q     <= '0;
            ts_q       <= '0;
            trig_ts_q  <= '0;
            trig_cnt_q <= '0;
            ovr_q      <= '0;
            max_q      <= SumMin;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            below_q    <= below_d;
            beat_q     <= beat_d;
            ts_q       <= ts_d;
            trig_ts_q  <= trig_ts_d;
            trig_cnt_q <= trig_cnt_d;
            ovr_q      <= ovr_d;
            max_q      <= max_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign state         = state_q;
    assign sample_ts     = ts_q;
    assign trig_ts       = trig_ts_q;
    assign trig_count    = trig_cnt_q;
    assign overrun_count = ovr_q;
    assign max_sum       = max_q;

endmodule

// File: tb/tb_adc_trig_packetizer.sv
// Directed bench for adc_trig_packetizer with NUM_CH=2, 14-bit samples, 8-beat packets.
module tb_adc_trig_packetizer;
    localparam int unsigned NCh   = 2;
    localparam int unsigned SumW  = 15;
    localparam logic [SumW-1:0] SumMin = 15'h4000;

    logic            aclk = 1'b0;
    logic            areset = 1'b0;
    logic [31:0]     adc_dat = '0;
    logic            adc_valid = 1'b0;
    logic [3:0]      dec_log2 = '0;
    logic [SumW-1:0] trig_level = '0;
    logic [SumW-1:0] trig_hyst = '0;
    logic            arm = 1'b0;
    logic            abort = 1'b0;
    logic            clear_stats = 1'b0;
    logic [1:0]      state;
    logic [63:0]     sample_ts, trig_ts;
    logic [15:0]     trig_count, overrun_count;
    logic [SumW-1:0] max_sum;

    int total = 0;
    int bad = 0;

    adc_trig_packetizer_if #(.NUM_CH(NCh)) axis ();

    adc_trig_packetizer #(
        .NUM_CH         (NCh),
        .ADC_DATA_WIDTH (14),
        .PKT_LEN        (8),
        .MAX_DEC_LOG2   (8)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .adc_dat       (adc_dat),
        .adc_valid     (adc_valid),
        .dec_log2      (dec_log2),
        .trig_level    (trig_level),
        .trig_hyst     (trig_hyst),
        .arm           (arm),
        .abort         (abort),
        .clear_stats   (clear_stats),
        .m_axis        (axis.master),
        .state         (state),
        .sample_ts     (sample_ts),
        .trig_ts       (trig_ts),
        .trig_count    (trig_count),
        .overrun_count (overrun_count),
        .max_sum       (max_sum)
    );

    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input int c0, input int c1);
        adc_dat   = {16'(c1), 16'(c0)};
        adc_valid = 1'b1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        axis.tready = 1'b0;
        tick();
        tick();
        areset = 1'b0;
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (axis.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", axis.tvalid); end
        total++; if (axis.tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b exp=0", axis.tlast); end
        total++; if (sample_ts !== 64'd0) begin bad++; $display("FAIL reset_ts got=%0d exp=0", sample_ts); end
        total++; if (trig_count !== 16'd0) begin bad++; $display("FAIL reset_trigcnt got=%0d exp=0", trig_count); end
        total++; if (overrun_count !== 16'd0) begin bad++; $display("FAIL reset_ovr got=%0d exp=0", overrun_count); end
        total++; if (max_sum !== SumMin) begin bad++; $display("FAIL reset_max got=%h exp=%h", max_sum, SumMin); end
    endtask

    task automatic test_decimation();
        dec_log2 = 4'd2;
        for (int i = 0; i < 4; i++) begin
            drive(10 + i, (i == 3) ? -3 : -4);
            tick();
            total++; if (sample_ts !== 64'd0) begin bad++; $display("FAIL dec_early i=%0d got=%0d exp=0", i, sample_ts); end
        end
        adc_valid = 1'b0;
        tick();
        // Lanes 11 and -4 give a sum of 7.
        total++; if (sample_ts !== 64'd1) begin bad++; $display("FAIL dec_latency got=%0d exp=1", sample_ts); end
        total++; if (max_sum !== 15'd7) begin bad++; $display("FAIL dec_sum got=%h exp=0007", max_sum); end
        tick();
        total++; if (sample_ts !== 64'd1) begin bad++; $display("FAIL dec_pulse got=%0d exp=1", sample_ts); end
    endtask

    task automatic test_trigger_packet();
        int  beats;
        bit  seen_cap;
        logic [31:0] exp_d;
        beats = 0;
        seen_cap = 1'b0;
        dec_log2 = 4'd0;
        trig_level = 15'd20;
        trig_hyst = 15'd4;
        axis.tready = 1'b1;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        total++; if (state !== 2'd1) begin bad++; $display("FAIL arm_state got=%0d exp=1", state); end
        for (int i = 0; i < 38; i++) begin
            drive(3 + i, 5 + i);
            tick();
            if (state === 2'd2 && !seen_cap) begin
                seen_cap = 1'b1;
                total++; if (trig_ts !== 64'd6) begin bad++; $display("FAIL trig_ts got=%0d exp=6", trig_ts); end
                total++; if (trig_count !== 16'd1) begin bad++; $display("FAIL trig_cnt got=%0d exp=1", trig_count); end
            end
            if (axis.tvalid === 1'b1) begin
                exp_d = {16'(11 + beats), 16'(9 + beats)};
                total++; if (axis.tdata !== exp_d) begin bad++; $display("FAIL beat_data k=%0d got=%h exp=%h", beats, axis.tdata, exp_d); end
                total++; if (axis.tlast !== (beats == 7)) begin bad++; $display("FAIL beat_last k=%0d got=%b", beats, axis.tlast); end
                beats++;
            end
        end
        adc_valid = 1'b0;
        tick();
        tick();
        total++; if (!seen_cap) begin bad++; $display("FAIL capture_seen got=0 exp=1"); end
        total++; if (beats !== 8) begin bad++; $display("FAIL beat_count got=%0d exp=8", beats); end
        total++; if (state !== 2'd1) begin bad++; $display("FAIL rearm_state got=%0d exp=1", state); end
        total++; if (trig_count !== 16'd1) begin bad++; $display("FAIL no_retrig got=%0d exp=1", trig_count); end
        total++; if (max_sum !== 15'd82) begin bad++; $display("FAIL ramp_max got=%0d exp=82", max_sum); end
    endtask

    task automatic test_backpressure();
        axis.tready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            drive(3 + i, 5 + i);
            tick();
            if (i == 10) begin
                total++; if (axis.tdata !== 32'h000B_0009) begin bad++; $display("FAIL bp_hold got=%h exp=000b0009", axis.tdata); end
                total++; if (axis.tlast !== 1'b0) begin bad++; $display("FAIL bp_early_last got=%b exp=0", axis.tlast); end
            end
        end
        adc_valid = 1'b0;
        tick();
        tick();
        total++; if (overrun_count !== 16'd7) begin bad++; $display("FAIL bp_overrun got=%0d exp=7", overrun_count); end
        total++; if (axis.tvalid !== 1'b1) begin bad++; $display("FAIL bp_tvalid got=%b exp=1", axis.tvalid); end
        total++; if (axis.tlast !== 1'b1) begin bad++; $display("FAIL bp_forced_last got=%b exp=1", axis.tlast); end
        total++; if (axis.tdata !== 32'h000B_0009) begin bad++; $display("FAIL bp_data got=%h exp=000b0009", axis.tdata); end
        total++; if (state !== 2'd3) begin bad++; $display("FAIL bp_drain got=%0d exp=3", state); end
        total++; if (trig_ts !== 64'd44) begin bad++; $display("FAIL bp_trig_ts got=%0d exp=44", trig_ts); end
        total++; if (trig_count !== 16'd2) begin bad++; $display("FAIL bp_trig_cnt got=%0d exp=2", trig_count); end
        axis.tready = 1'b1;
        tick();
        total++; if (axis.tvalid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", axis.tvalid); end
        tick();
        total++; if (state !== 2'd1) begin bad++; $display("FAIL bp_rearm got=%0d exp=1", state); end
    endtask

    task automatic test_stats();
        drive(100, 100);
        tick();
        adc_valid = 1'b0;
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        total++; if (max_sum !== SumMin) begin bad++; $display("FAIL clr_max got=%h exp=%h", max_sum, SumMin); end
        total++; if (trig_count !== 16'd0) begin bad++; $display("FAIL clr_trig got=%0d exp=0", trig_count); end
        total++; if (overrun_count !== 16'd0) begin bad++; $display("FAIL clr_ovr got=%0d exp=0", overrun_count); end
        drive(2, 3);
        tick();
        adc_valid = 1'b0;
        tick();
        total++; if (max_sum !== 15'd5) begin bad++; $display("FAIL max_after_clr got=%0d exp=5", max_sum); end
        total++; if (state !== 2'd1) begin bad++; $display("FAIL stats_state got=%0d exp=1", state); end
    endtask

    task automatic test_abort();
        axis.tready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(3 + i, 5 + i);
            tick();
        end
        adc_valid = 1'b0;
        tick();
        total++; if (axis.tvalid !== 1'b1 || state !== 2'd2) begin bad++; $display("FAIL pre_abort tvalid=%b state=%0d exp 1/2", axis.tvalid, state); end
        total++; if (axis.tdata !== 32'h000D_000B) begin bad++; $display("FAIL beat2_data got=%h exp=000d000b", axis.tdata); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if (axis.tvalid !== 1'b0) begin bad++; $display("FAIL abort_tvalid got=%b exp=0", axis.tvalid); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL abort_state got=%0d exp=0", state); end
        arm = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL arm_abort got=%0d exp=0", state); end
    endtask

    task automatic test_reset_mid_capture();
        axis.tready = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(3 + i, 5 + i);
            tick();
        end
        adc_valid = 1'b0;
        total++; if (state !== 2'd2 || axis.tvalid !== 1'b1) begin bad++; $display("FAIL mid_cap state=%0d tvalid=%b exp 2/1", state, axis.tvalid); end
        areset = 1'b1;
        tick();
        areset = 1'b0;
        total++; if (state !== 2'd0) begin bad++; $display("FAIL mrst_state got=%0d exp=0", state); end
        total++; if (axis.tvalid !== 1'b0 || axis.tlast !== 1'b0) begin bad++; $display("FAIL mrst_axis tvalid=%b tlast=%b exp 0/0", axis.tvalid, axis.tlast); end
        total++; if (axis.tdata !== 32'h0) begin bad++; $display("FAIL mrst_tdata got=%h exp=0", axis.tdata); end
        total++; if (trig_ts !== 64'd0 || trig_count !== 16'd0) begin bad++; $display("FAIL mrst_trig ts=%0d cnt=%0d exp 0/0", trig_ts, trig_count); end
        total++; if (overrun_count !== 16'd0) begin bad++; $display("FAIL mrst_ovr got=%0d exp=0", overrun_count); end
        total++; if (max_sum !== SumMin) begin bad++; $display("FAIL mrst_max got=%h exp=%h", max_sum, SumMin); end
        tick();
        total++; if (sample_ts !== 64'd0 || axis.tvalid !== 1'b0) begin bad++; $display("FAIL mrst_quiet ts=%0d tvalid=%b exp 0/0", sample_ts, axis.tvalid); end
    endtask

    initial begin
        test_reset();
        test_decimation();
        test_trigger_packet();
        test_backpressure();
        test_stats();
        test_abort();
        test_reset_mid_capture();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
